var_delay_line: RTL
===================

VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the data word width in bits.
REQ-002 The block SHALL take parameter MAX_DELAY, default 32, as the number of physical stages (legal range 2..256).
REQ-003 The block SHALL take parameter DEF_DELAY, default 24, as the active delay after reset (legal range 1..MAX_DELAY).
REQ-004 The block SHALL define localparam DW = clog2(MAX_DELAY+1) as the delay and occupancy field width.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  advance strobe; low freezes all stages and counters.
REQ-008 flush  input  1  synchronous clear of all in-flight entries.
REQ-009 in_valid  input  1  in_data holds a word to insert.
REQ-010 in_data  input  WIDTH  input word.
REQ-011 in_ready  output  1  equals (state==RUN) & en; a word is accepted only when in_valid & in_ready.
REQ-012 dly_sel  input  DW  requested delay in en-cycles, legal 1..MAX_DELAY.
REQ-013 out_valid  output  1  the valid bit of stage dly_cur-1.
REQ-014 out_data  output  WIDTH  data of stage dly_cur-1 when out_valid is high, all zeros otherwise.
REQ-015 occupancy  output  DW  number of valid entries in stages 0..dly_cur-1.
REQ-016 dly_cur  output  DW  the active delay.
REQ-017 dly_err  output  1  sticky flag set by an illegal dly_sel.

Function
REQ-018 On an en edge: stage 0 SHALL load {accept, in_data}; stage i (1 <= i < dly_cur) SHALL load stage i-1; stages i >= dly_cur SHALL load valid=0.
REQ-019 A word accepted at en-edge k SHALL appear on out_valid/out_data after exactly dly_cur en-edges, in order, with no loss or duplication; en-low cycles add latency only.
REQ-020 occupancy SHALL update +1 on accept, -1 when out_valid & en, and stay unchanged when both occur on the same edge.
REQ-021 The state machine SHALL have two states, RUN and DRAIN.
REQ-022 In RUN, when dly_sel is legal, differs from dly_cur, and occupancy==0, the block SHALL load dly_cur on that edge and remain in RUN.
REQ-023 In RUN, when dly_sel is legal, differs from dly_cur, and occupancy!=0, the block SHALL go to DRAIN with no dly_cur change.
REQ-024 In DRAIN, in_ready SHALL be 0 while shifting continues on en, so in-flight words exit with the old delay.
REQ-025 DRAIN SHALL exit to RUN when occupancy reaches 0, loading dly_sel if it is legal and keeping dly_cur otherwise.
REQ-026 DRAIN SHALL exit to RUN without a load when dly_sel returns to dly_cur.
REQ-027 A dly_sel of 0 or above MAX_DELAY SHALL be ignored and SHALL set dly_err from the next edge until reset.
REQ-028 flush SHALL have priority over shift and accept, and act regardless of en.
REQ-029 On a flush edge, all valid bits and occupancy SHALL clear and the next state SHALL be RUN.
REQ-030 On a flush edge, dly_cur SHALL load dly_sel if it is legal.
REQ-031 With en low, state, stages, occupancy and dly_cur SHALL hold; only flush and rst act.

Reset
REQ-032 While rst is asserted: state = RUN, all valid bits = 0, occupancy = 0, dly_cur = DEF_DELAY, dly_err = 0, out_valid = 0, out_data = 0.
REQ-033 Data registers SHALL NOT require reset, because output masking hides their content.

Structure
REQ-034 A shared package dly_pkg SHALL hold the state enum (RUN, DRAIN) and the clog2 helper.
REQ-035 Sub-module dly_stage SHALL implement one stage: a WIDTH-bit data register plus an async-cleared valid bit with enable, instantiated MAX_DELAY times via generate.

Verification (WIDTH=32, MAX_DELAY=8, DEF_DELAY=4)
REQ-036 Reset, then en=1 and words 0x1..0x6 on consecutive cycles: outputs 0x1..0x6 SHALL appear 4 cycles later in order, and out_data SHALL be 0 between words.
REQ-037 en held low 2 cycles mid-stream: latency SHALL become 6 for the affected words, with no loss or duplication.
REQ-038 dly_sel 4->6 with 3 words in flight: in_ready SHALL go low, the 3 words SHALL exit at delay 4, then dly_cur SHALL be 6 and in_ready high.
REQ-039 flush during DRAIN: on the next cycle out_valid SHALL be 0, occupancy 0, dly_cur the new value, and state RUN.
REQ-040 dly_sel=0, then dly_sel=9: dly_err SHALL be 1 and dly_cur SHALL stay 4.
REQ-041 rst pulsed between edges with 5 words in flight: out_valid and occupancy SHALL be 0 immediately, and dly_cur SHALL be 4.

Source files
------------

// File: rtl/dly_pkg.sv
// Shared definitions for the variable-length delay line: controller states
// and the width helper used to size the delay/occupancy fields.
package dly_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } dly_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dly_stage.sv
// One delay-line stage: data register without reset plus a valid bit that is
// cleared asynchronously by rst and synchronously by clr.
module dly_stage
    import dly_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (ld) begin
            valid_d = d_valid;
            data_d  = d_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Data content is hidden by the valid mask downstream, so no reset needed.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;

endmodule

// File: rtl/var_delay_line.sv
// Delay line with run-time selectable length. A delay change waits for the
// line to drain so that in-flight words always leave with the delay they entered with.
module var_delay_line
    import dly_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int MAX_DELAY = 32,
    parameter  int DEF_DELAY = 24,
    localparam int DW        = clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [DW-1:0]    dly_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DW-1:0]    occupancy,
    output logic [DW-1:0]    dly_cur,
    output logic             dly_err,
    output dly_state_e       state_dbg
);

    dly_state_e       state_q, state_d;
    logic [DW-1:0]    cur_q, cur_d;
    logic [DW-1:0]    occ_q, occ_d;
    logic             err_q, err_d;

    logic [MAX_DELAY-1:0] st_valid;
    logic [WIDTH-1:0]     st_data [MAX_DELAY];
    logic [MAX_DELAY-1:0] ld_valid;
    logic [WIDTH-1:0]     ld_data [MAX_DELAY];

    logic             accept;
    logic             sel_legal;
    logic             tap_valid;
    logic [WIDTH-1:0] tap_data;

    assign in_ready  = (state_q == RUN) & en;
    assign accept    = in_valid & in_ready;
    assign sel_legal = (dly_sel != '0) && (dly_sel <= DW'(MAX_DELAY));

    // Stages at or beyond the active delay are fed invalid so they stay empty.
    always_comb begin
        ld_valid    = '0;
        ld_valid[0] = accept;
        ld_data[0]  = in_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
            ld_valid[i] = (DW'(i) < cur_q) & st_valid[i-1];
            ld_data[i]  = st_data[i-1];
        end
    end

    for (genvar g = 0; g < MAX_DELAY; g++) begin : g_stage
        dly_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ld      (en),
            .clr     (flush),
            .d_valid (ld_valid[g]),
            .d_data  (ld_data[g]),
            .q_valid (st_valid[g]),
            .q_data  (st_data[g])
        );
    end

    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (DW'(i) == cur_q - DW'(1)) begin
                tap_valid = st_valid[i];
                tap_data  = st_data[i];
            end
        end
    end

    assign out_valid = tap_valid;
    assign out_data  = tap_valid ? tap_data : '0;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        occ_d   = occ_q;
        err_d   = err_q | ~sel_legal;
        if (flush) begin
            state_d = RUN;
            occ_d   = '0;
            if (sel_legal) cur_d = dly_sel;
        end else if (en) begin
            case ({accept, tap_valid})
                2'b10:   occ_d = occ_q + DW'(1);
                2'b01:   occ_d = occ_q - DW'(1);
                default: occ_d = occ_q;
            endcase
            case (state_q)
                RUN: begin
                    if (sel_legal && (dly_sel != cur_q)) begin
                        if (occ_q == '0) cur_d   = dly_sel;
                        else             state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (dly_sel == cur_q) begin
                        state_d = RUN;
                    end else if (occ_q == '0) begin
                        state_d = RUN;
                        if (sel_legal) cur_d = dly_sel;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cur_q   <= DW'(DEF_DELAY);
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    assign occupancy = occ_q;
    assign dly_cur   = cur_q;
    assign dly_err   = err_q;
    assign state_dbg = state_q;

endmodule
